// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared types and constants for the MEM-stage access unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] c_BE_B = 4'b0001;
    localparam logic [3:0] c_BE_H = 4'b0011;
    localparam logic [3:0] c_BE_W = 4'b1111;

    // Any funct3 outside the five defined encodings behaves as a word access.
    function automatic size_t size_of(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: size_of = SZ_B;
            F3_H, F3_HU: size_of = SZ_H;
            default:     size_of = SZ_W;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Selects the addressed byte/half of a read word and extends it.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_offset, 3'b000} +: 8];
    assign w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_result = i_rdata;
        case (i_funct3)
            F3_B:    o_result = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_result = {24'd0, w_byte};
            F3_H:    o_result = {{16{w_half[15]}}, w_half};
            F3_HU:   o_result = {16'd0, w_half};
            default: o_result = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage controller running a req/ack data-memory handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [4:0]        RDaddr_i,
    input  logic [31:0]       ALUresult_i,
    input  logic [31:0]       RS2data_i,
    input  logic [2:0]        funct3_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              MemtoReg_i,
    input  logic              RegWrite_i,
    output logic [4:0]        RDaddr_o,
    output logic [31:0]       ALUresult_o,
    output logic [31:0]       MEMdata_o,
    output logic              MemtoReg_o,
    output logic              RegWrite_o,
    output logic              stall_o,
    output logic              misalign_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [31:0]       dmem_wdata_o,
    input  logic [31:0]       dmem_rdata_i,
    input  logic              dmem_ack_i
);

    state_t      r_state;
    state_t      w_next;
    logic        r_req;
    logic        r_misalign;
    logic [31:0] r_rdata;

    logic        w_memop;
    logic        w_load;
    logic        w_misaligned;
    logic        w_issue;
    logic        w_stall;
    logic [1:0]  w_offset;
    size_t       w_size;
    logic [31:0] w_loaded;

    assign w_memop      = MemRead_i | MemWrite_i;
    assign w_load       = MemRead_i & ~MemWrite_i;
    assign w_offset     = ALUresult_i[1:0];
    assign w_size       = size_of(funct3_i);
    assign w_misaligned = ((w_size == SZ_H) && w_offset[0]) ||
                          ((w_size == SZ_W) && (w_offset != 2'b00));
    assign w_issue      = (r_state == IDLE) && w_memop && !w_misaligned;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_issue) w_next = BUSY;
            BUSY:    if (dmem_ack_i) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_req      <= 1'b0;
            r_rdata    <= 32'd0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= (r_state == IDLE) && w_memop && w_misaligned;
            if (w_issue) begin
                r_req <= 1'b1;
            end else if ((r_state == BUSY) && dmem_ack_i) begin
                r_req   <= 1'b0;
                r_rdata <= dmem_rdata_i;
            end
        end
    end

    load_align u_load_align (
        .i_rdata  (r_rdata),
        .i_offset (w_offset),
        .i_funct3 (funct3_i),
        .o_result (w_loaded)
    );

    always_comb begin
        RDaddr_o    = RDaddr_i;
        ALUresult_o = ALUresult_i;
        MemtoReg_o  = MemtoReg_i;
        RegWrite_o  = RegWrite_i;
        MEMdata_o   = 32'd0;
        w_stall     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_memop) begin
                    RDaddr_o   = 5'd0;
                    MemtoReg_o = 1'b0;
                    RegWrite_o = 1'b0;
                    w_stall    = !w_misaligned;
                end
            end
            BUSY: begin
                RDaddr_o   = 5'd0;
                MemtoReg_o = 1'b0;
                RegWrite_o = 1'b0;
                w_stall    = 1'b1;
            end
            DONE: begin
                MEMdata_o = w_load ? w_loaded : 32'd0;
            end
            default: ;
        endcase
    end

    // The upstream pipeline is being reset as well, so it must not be held frozen.
    assign stall_o    = w_stall & ~rst_i;
    assign misalign_o = r_misalign;
    assign dmem_req_o = r_req;

    assign dmem_we_o   = MemWrite_i;
    assign dmem_addr_o = {ALUresult_i[ADDR_W-1:2], 2'b00};

    always_comb begin
        dmem_be_o    = c_BE_W;
        dmem_wdata_o = RS2data_i;
        if (MemWrite_i) begin
            case (w_size)
                SZ_B: begin
                    dmem_be_o    = c_BE_B << w_offset;
                    dmem_wdata_o = {4{RS2data_i[7:0]}};
                end
                SZ_H: begin
                    dmem_be_o    = c_BE_H << w_offset;
                    dmem_wdata_o = {2{RS2data_i[15:0]}};
                end
                default: begin
                    dmem_be_o    = c_BE_W;
                    dmem_wdata_o = RS2data_i;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  RDaddr_i;
    logic [31:0] ALUresult_i;
    logic [31:0] RS2data_i;
    logic [2:0]  funct3_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic        MemtoReg_i;
    logic        RegWrite_i;
    logic [4:0]  RDaddr_o;
    logic [31:0] ALUresult_o;
    logic [31:0] MEMdata_o;
    logic        MemtoReg_o;
    logic        RegWrite_o;
    logic        stall_o;
    logic        misalign_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic [31:0] dmem_rdata_i;
    logic        dmem_ack_i;

    int n_chk  = 0;
    int n_pass = 0;

    logic        exp_valid = 1'b0;
    logic        exp_stall, exp_m2r, exp_rw, exp_mis, exp_req, exp_chk_alu, exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_alu, exp_mem, exp_wdata, exp_addr;
    logic [3:0]  exp_be;
    logic        mis_pending = 1'b0;

    always #5 clk_i = ~clk_i;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .RDaddr_i     (RDaddr_i),
        .ALUresult_i  (ALUresult_i),
        .RS2data_i    (RS2data_i),
        .funct3_i     (funct3_i),
        .MemRead_i    (MemRead_i),
        .MemWrite_i   (MemWrite_i),
        .MemtoReg_i   (MemtoReg_i),
        .RegWrite_i   (RegWrite_i),
        .RDaddr_o     (RDaddr_o),
        .ALUresult_o  (ALUresult_o),
        .MEMdata_o    (MEMdata_o),
        .MemtoReg_o   (MemtoReg_o),
        .RegWrite_o   (RegWrite_o),
        .stall_o      (stall_o),
        .misalign_o   (misalign_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_rdata_i (dmem_rdata_i),
        .dmem_ack_i   (dmem_ack_i)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference model: access size in bytes, lanes and extension by plain arithmetic.
    function automatic int ref_size(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic ref_misaligned(input logic [2:0] f3, input logic [31:0] addr);
        int off = int'(addr % 4);
        if (ref_size(f3) == 2) return (off % 2) != 0;
        if (ref_size(f3) == 4) return off != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [2:0] f3);
        logic [31:0] v = word >> (8 * (addr % 4));
        if (ref_size(f3) == 1) begin
            v = v % 256;
            if (f3 == 3'd0 && v >= 128) v = v - 256;
        end else if (ref_size(f3) == 2) begin
            v = v % 65536;
            if (f3 == 3'd1 && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr,
                                          input logic store);
        if (!store) return 4'd15;
        if (ref_size(f3) == 1) return 4'(1 << (addr % 4));
        if (ref_size(f3) == 2) return 4'(3 << (addr % 4));
        return 4'd15;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] rs2,
                                              input logic store);
        if (store && ref_size(f3) == 1) return (rs2 % 256) * 32'h01010101;
        if (store && ref_size(f3) == 2) return (rs2 % 65536) * 32'h00010001;
        return rs2;
    endfunction

    task automatic set_wb(input logic bubble, input logic [4:0] rd, input logic [31:0] alu,
                          input logic m2r, input logic rw);
        exp_rd      = bubble ? 5'd0 : rd;
        exp_m2r     = bubble ? 1'b0 : m2r;
        exp_rw      = bubble ? 1'b0 : rw;
        exp_alu     = alu;
        exp_chk_alu = !bubble;
    endtask

    // One instruction through MEM; the memory acks on the (delay+1)-th cycle of req.
    task automatic run_instr(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rs2,
                             input logic [2:0] f3, input logic mr, input logic mw,
                             input logic m2r, input logic rw, input int delay,
                             input logic [31:0] rdata, input logic [31:0] lit_mem,
                             input int lit_stall, input logic spur_ack);
        int   stalls = 0;
        logic memop  = mr | mw;
        logic mis    = memop && ref_misaligned(f3, alu);
        @(posedge clk_i); #1;
        RDaddr_i = rd; ALUresult_i = alu; RS2data_i = rs2; funct3_i = f3;
        MemRead_i = mr; MemWrite_i = mw; MemtoReg_i = m2r; RegWrite_i = rw;
        dmem_ack_i = spur_ack; dmem_rdata_i = $urandom;
        exp_mis   = mis_pending;
        exp_we    = mw;
        exp_be    = ref_be(f3, alu, mw);
        exp_wdata = ref_wdata(f3, rs2, mw);
        exp_addr  = {alu[31:2], 2'b00};
        exp_req   = 1'b0;
        exp_mem   = 32'd0;
        exp_valid = 1'b1;
        if (!memop || mis) begin
            set_wb(mis, rd, alu, m2r, rw);
            exp_stall = 1'b0;
            @(negedge clk_i);
            if (stall_o) stalls++;
            chk("memdata_lit", MEMdata_o, lit_mem);
            mis_pending = mis;
        end else begin
            set_wb(1'b1, rd, alu, m2r, rw);
            exp_stall = 1'b1;
            @(negedge clk_i);
            if (stall_o) stalls++;
            mis_pending = 1'b0;
            for (int k = 0; k <= delay; k++) begin
                @(posedge clk_i); #1;
                exp_mis      = 1'b0;
                exp_req      = 1'b1;
                dmem_ack_i   = (k == delay);
                dmem_rdata_i = (k == delay) ? rdata : $urandom;
                @(negedge clk_i);
                if (stall_o) stalls++;
            end
            @(posedge clk_i); #1;
            dmem_ack_i = 1'b0; dmem_rdata_i = $urandom;
            exp_req   = 1'b0;
            exp_stall = 1'b0;
            set_wb(1'b0, rd, alu, m2r, rw);
            exp_mem   = (mr && !mw) ? ref_load(rdata, alu, f3) : 32'd0;
            @(negedge clk_i);
            if (stall_o) stalls++;
            chk("memdata_lit", MEMdata_o, lit_mem);
        end
        chk("stall_cycles", stalls, lit_stall);
    endtask

    always @(negedge clk_i) begin
        if (exp_valid && !rst_i) begin
            chk("stall", 32'(stall_o), 32'(exp_stall));
            chk("rdaddr", 32'(RDaddr_o), 32'(exp_rd));
            chk("regwrite", 32'(RegWrite_o), 32'(exp_rw));
            chk("memtoreg", 32'(MemtoReg_o), 32'(exp_m2r));
            if (exp_chk_alu) chk("aluresult", ALUresult_o, exp_alu);
            chk("memdata", MEMdata_o, exp_mem);
            chk("misalign", 32'(misalign_o), 32'(exp_mis));
            chk("req", 32'(dmem_req_o), 32'(exp_req));
            if (exp_req) begin
                chk("we", 32'(dmem_we_o), 32'(exp_we));
                chk("be", 32'(dmem_be_o), 32'(exp_be));
                chk("wdata", dmem_wdata_o, exp_wdata);
                chk("addr", dmem_addr_o, exp_addr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        RDaddr_i = 5'd0; ALUresult_i = 32'd0; RS2data_i = 32'd0; funct3_i = 3'd0;
        MemRead_i = 1'b0; MemWrite_i = 1'b0; MemtoReg_i = 1'b0; RegWrite_i = 1'b0;
        dmem_rdata_i = 32'd0; dmem_ack_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_req", 32'(dmem_req_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_misalign", 32'(misalign_o), 32'd0);
        chk("rst_memdata", MEMdata_o, 32'd0);
        rst_i = 1'b0;

        //        rd     alu           rs2           f3      mr mw m2r rw dly rdata         lit           st spur
        run_instr(5'd5,  32'h1234,     32'h0,        3'b000, 0, 0, 0,  1, 0,  32'h0,        32'h0,        0, 0);
        run_instr(5'd10, 32'h100,      32'h0,        3'b010, 1, 0, 1,  1, 1,  32'hDEADBEEF, 32'hDEADBEEF, 3, 0);
        run_instr(5'd11, 32'h103,      32'h0,        3'b000, 1, 0, 1,  1, 0,  32'h80112233, 32'hFFFFFF80, 2, 0);
        run_instr(5'd12, 32'h103,      32'h0,        3'b100, 1, 0, 1,  1, 2,  32'h80112233, 32'h00000080, 4, 0);
        run_instr(5'd13, 32'h102,      32'h0,        3'b101, 1, 0, 1,  1, 0,  32'h80112233, 32'h00008011, 2, 0);
        run_instr(5'd14, 32'h100,      32'h0,        3'b001, 1, 0, 1,  1, 1,  32'h1234F00D, 32'hFFFFF00D, 3, 0);
        run_instr(5'd0,  32'h101,      32'hAB,       3'b000, 0, 1, 0,  0, 0,  32'h0,        32'h0,        2, 0);
        run_instr(5'd0,  32'h102,      32'h5678CAFE, 3'b001, 0, 1, 0,  0, 1,  32'h0,        32'h0,        3, 0);
        run_instr(5'd0,  32'h108,      32'h11223344, 3'b010, 0, 1, 0,  0, 0,  32'h0,        32'h0,        2, 0);
        run_instr(5'd9,  32'h102,      32'h0,        3'b010, 1, 0, 1,  1, 0,  32'h0,        32'h0,        0, 0);
        run_instr(5'd3,  32'h55,       32'h0,        3'b000, 0, 0, 0,  1, 0,  32'h0,        32'h0,        0, 0);
        run_instr(5'd0,  32'h101,      32'h77,       3'b001, 0, 1, 0,  0, 0,  32'h0,        32'h0,        0, 0);
        run_instr(5'd0,  32'h0,        32'h0,        3'b000, 0, 0, 0,  0, 0,  32'h0,        32'h0,        0, 0);
        run_instr(5'd6,  32'h10C,      32'h99,       3'b010, 1, 1, 1,  1, 0,  32'h12345678, 32'h0,        2, 0);
        run_instr(5'd7,  32'h104,      32'h0,        3'b011, 1, 0, 1,  1, 0,  32'hCAFEF00D, 32'hCAFEF00D, 2, 0);
        run_instr(5'd8,  32'h106,      32'h0,        3'b011, 1, 0, 1,  1, 0,  32'h0,        32'h0,        0, 0);

        // Reset in the middle of an outstanding load.
        @(posedge clk_i); #1;
        exp_valid = 1'b0;
        RDaddr_i = 5'd4; ALUresult_i = 32'h200; funct3_i = 3'b010;
        MemRead_i = 1'b1; MemWrite_i = 1'b0; MemtoReg_i = 1'b1; RegWrite_i = 1'b1;
        dmem_ack_i = 1'b0;
        @(posedge clk_i); #1;
        chk("busy_req", 32'(dmem_req_o), 32'd1);
        chk("busy_stall", 32'(stall_o), 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("rst_async_req", 32'(dmem_req_o), 32'd0);
        chk("rst_async_stall", 32'(stall_o), 32'd0);
        @(posedge clk_i); #1;
        MemRead_i = 1'b0; MemtoReg_i = 1'b0; RegWrite_i = 1'b0;
        rst_i = 1'b0;
        mis_pending = 1'b0;

        run_instr(5'd2,  32'h44,       32'h0,        3'b000, 0, 0, 0,  1, 0,  32'h0,        32'h0,        0, 1);
        run_instr(5'd1,  32'h48,       32'h0,        3'b000, 0, 0, 0,  1, 0,  32'h0,        32'h0,        0, 0);
        run_instr(5'd4,  32'h200,      32'h0,        3'b010, 1, 0, 1,  1, 0,  32'h0BADF00D, 32'h0BADF00D, 2, 0);

        @(posedge clk_i); #1;
        exp_valid = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
